pong_pad_reader: RTL and testbench



---
 rtl/pong_pad_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/pong_pad_reader.sv | 162 ++++++++++++++++
 tb/tb_pong_pad_reader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pad_pkg.sv
// Shared types and constants for the NES-style gamepad poller.
package pong_pad_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLatch,
      StShift,
      StUpdate
   } pad_state_e;

   // Shift index of each button as clocked out of the pad.
   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   // A floating or unplugged data line reads low on every bit, which looks like
   // every button pressed at once.
   localparam logic [7:0] DISCONNECT_PAT = 8'h00;

   // Active-low raw shift word to active-high buttons, blanked when unplugged.
   function automatic logic [7:0] decode_buttons(input logic [7:0] raw);
      return (raw == DISCONNECT_PAT) ? 8'h00 : ~raw;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous pad data line; resets to the
// idle (released) level.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   // Double-register the asynchronous input.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         q      <= 1'b1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/pong_pad_reader.sv
// Periodically polls two serial gamepads and presents registered paddle and
// score-reset controls for the pong core.
module pong_pad_reader #(
   parameter int unsigned POLL_DIV = 251750,
   parameter int unsigned HALF_BIT = 151
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pad_data_l,
   input  logic       pad_data_r,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic       left_up,
   output logic       left_down,
   output logic       right_up,
   output logic       right_down,
   output logic       score_reset,
   output logic [7:0] btn_l,
   output logic [7:0] btn_r,
   output logic       pad_present_l,
   output logic       pad_present_r,
   output logic       sample_valid
);

   import pong_pad_pkg::*;

   logic        data_l_s, data_r_s;
   logic [17:0] poll_cnt_q;
   logic        tick;
   pad_state_e  state_q;
   logic [9:0]  timer_q;
   logic        phase_q;   // second half of the current latch pulse or bit
   logic [2:0]  bit_q;
   logic [7:0]  raw_l_q, raw_r_q;
   logic        half_done;
   logic [7:0]  btn_l_d, btn_r_d;

   sync_2ff u_sync_l (
      .clk (clk),
      .rst (rst),
      .d   (pad_data_l),
      .q   (data_l_s)
   );

   sync_2ff u_sync_r (
      .clk (clk),
      .rst (rst),
      .d   (pad_data_r),
      .q   (data_r_s)
   );

   assign tick      = (poll_cnt_q == 18'(POLL_DIV - 1));
   assign half_done = (timer_q == 10'(HALF_BIT - 1));

   // Free-running poll divider; keeps counting while a transaction runs.
   always_ff @(posedge clk) begin
      if (rst || tick) begin
         poll_cnt_q <= '0;
      end else begin
         poll_cnt_q <= poll_cnt_q + 18'd1;
      end
   end

   // Decoded button view of the assembled shift words.
   always_comb begin
      btn_l_d = decode_buttons(raw_l_q);
      btn_r_d = decode_buttons(raw_r_q);
   end

   // Poll sequencer: latch pulse, eight clocked bits, then publish outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         timer_q       <= '0;
         phase_q       <= 1'b0;
         bit_q         <= '0;
         raw_l_q       <= '1;
         raw_r_q       <= '1;
         pad_latch     <= 1'b0;
         pad_clk       <= 1'b1;
         left_up       <= 1'b0;
         left_down     <= 1'b0;
         right_up      <= 1'b0;
         right_down    <= 1'b0;
         score_reset   <= 1'b0;
         btn_l         <= '0;
         btn_r         <= '0;
         pad_present_l <= 1'b0;
         pad_present_r <= 1'b0;
         sample_valid  <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (tick) begin
                  state_q   <= StLatch;
                  pad_latch <= 1'b1;
                  timer_q   <= '0;
                  phase_q   <= 1'b0;
               end
            end
            StLatch: begin
               // Latch spans two half-bit periods so the timer stays 10 bits wide.
               if (half_done) begin
                  timer_q <= '0;
                  if (phase_q) begin
                     state_q   <= StShift;
                     pad_latch <= 1'b0;
                     pad_clk   <= 1'b0;
                     phase_q   <= 1'b0;
                     bit_q     <= '0;
                  end else begin
                     phase_q <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + 10'd1;
               end
            end
            StShift: begin
               if (half_done) begin
                  timer_q <= '0;
                  if (!phase_q) begin
                     // Last cycle of the low phase: data has had a full half-bit
                     // to settle through the synchronizer.
                     raw_l_q[bit_q] <= data_l_s;
                     raw_r_q[bit_q] <= data_r_s;
                     pad_clk        <= 1'b1;
                     phase_q        <= 1'b1;
                  end else if (bit_q == 3'd7) begin
                     // Outputs land on entry to StUpdate so the pulse and the
                     // new values appear in the same cycle.
                     state_q       <= StUpdate;
                     sample_valid  <= 1'b1;
                     btn_l         <= btn_l_d;
                     btn_r         <= btn_r_d;
                     pad_present_l <= (raw_l_q != DISCONNECT_PAT);
                     pad_present_r <= (raw_r_q != DISCONNECT_PAT);
                     left_up       <= btn_l_d[BTN_UP] & ~btn_l_d[BTN_DOWN];
                     left_down     <= btn_l_d[BTN_DOWN] & ~btn_l_d[BTN_UP];
                     right_up      <= btn_r_d[BTN_UP] & ~btn_r_d[BTN_DOWN];
                     right_down    <= btn_r_d[BTN_DOWN] & ~btn_r_d[BTN_UP];
                     score_reset   <= btn_l_d[BTN_START] | btn_r_d[BTN_START];
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     pad_clk <= 1'b0;
                     phase_q <= 1'b0;
                  end
               end else begin
                  timer_q <= timer_q + 10'd1;
               end
            end
            StUpdate: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_pad_reader.sv
// Self-checking bench for pong_pad_reader with a behavioural NES pad model.
module tb_pong_pad_reader;

   localparam int unsigned HB = 4;
   localparam int unsigned PD = 100;
   localparam int LATCH_TO_VALID = 18 * HB;  // tick->valid is 18*HB+1, latch rises tick+1

   typedef struct packed {
      logic [7:0] bl;
      logic [7:0] br;
      logic       pl;
      logic       pr;
      logic       lu;
      logic       ld;
      logic       ru;
      logic       rd;
      logic       sr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst_q = 1'b1;
   logic [7:0] raw_l = 8'hFF;
   logic [7:0] raw_r = 8'hFF;
   int         idx = 8;

   logic       pad_data_l, pad_data_r;
   logic       pad_latch, pad_clk;
   logic       left_up, left_down, right_up, right_down, score_reset;
   logic [7:0] btn_l, btn_r;
   logic       pad_present_l, pad_present_r, sample_valid;
   exp_t       act;

   int   total = 0;
   int   bad = 0;
   int   upd_cnt = 0;
   exp_t sb_q[$];

   pong_pad_reader #(
      .POLL_DIV (PD),
      .HALF_BIT (HB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pad_data_l    (pad_data_l),
      .pad_data_r    (pad_data_r),
      .pad_latch     (pad_latch),
      .pad_clk       (pad_clk),
      .left_up       (left_up),
      .left_down     (left_down),
      .right_up      (right_up),
      .right_down    (right_down),
      .score_reset   (score_reset),
      .btn_l         (btn_l),
      .btn_r         (btn_r),
      .pad_present_l (pad_present_l),
      .pad_present_r (pad_present_r),
      .sample_valid  (sample_valid)
   );

   always #5 clk = ~clk;

   // What the DUT saw on rst at the most recent active edge.
   always @(posedge clk) rst_q <= rst;

   // Pad model: latch reloads bit 0, each rising pad_clk presents the next bit.
   always @(posedge pad_latch or posedge pad_clk) begin
      if (pad_latch) idx <= 0;
      else           idx <= idx + 1;
   end
   assign pad_data_l = (idx < 8) ? raw_l[idx[2:0]] : 1'b1;
   assign pad_data_r = (idx < 8) ? raw_r[idx[2:0]] : 1'b1;

   always_comb begin
      act = {btn_l, btn_r, pad_present_l, pad_present_r,
             left_up, left_down, right_up, right_down, score_reset};
   end

   function automatic exp_t model(input logic [7:0] rl, input logic [7:0] rr);
      exp_t e;
      e.pl = (rl != 8'h00);
      e.pr = (rr != 8'h00);
      e.bl = e.pl ? ~rl : 8'h00;
      e.br = e.pr ? ~rr : 8'h00;
      e.lu = e.bl[4] & ~e.bl[5];
      e.ld = e.bl[5] & ~e.bl[4];
      e.ru = e.br[4] & ~e.br[5];
      e.rd = e.br[5] & ~e.br[4];
      e.sr = e.bl[3] | e.br[3];
      return e;
   endfunction

   // Monitor: protocol timing, scoreboard pops, and output hold between updates.
   initial begin
      int   cyc = 0;
      int   last_rise = -1;
      int   latch_len = 0;
      int   low_pulses = 0;
      int   cur_low = 0;
      bit   in_txn = 0;
      logic prev_latch = 1'b0;
      logic prev_clk = 1'b1;
      exp_t prev_act = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_q) begin
            total++;
            if (sample_valid !== 1'b0) begin
               bad++;
               $display("FAIL sv_in_reset sample_valid=%b required 0", sample_valid);
            end
            in_txn = 0; last_rise = -1; cur_low = 0; low_pulses = 0; latch_len = 0;
         end else begin
            if (pad_latch && !prev_latch) begin
               if (last_rise >= 0) begin
                  total++;
                  if (cyc - last_rise != PD) begin
                     bad++;
                     $display("FAIL poll_period got=%0d required=%0d", cyc - last_rise, PD);
                  end
               end
               last_rise = cyc; latch_len = 0; low_pulses = 0; cur_low = 0; in_txn = 1;
            end
            if (pad_latch) latch_len++;
            if (!pad_clk) begin
               cur_low++;
            end else if (!prev_clk) begin
               total++;
               if (cur_low != HB) begin
                  bad++;
                  $display("FAIL pad_clk_low_width got=%0d required=%0d", cur_low, HB);
               end
               low_pulses++;
               cur_low = 0;
            end
            if (sample_valid) begin
               total++;
               if (!in_txn || (cyc - last_rise != LATCH_TO_VALID)) begin
                  bad++;
                  $display("FAIL latency got=%0d required=%0d (in_txn=%0d)",
                           cyc - last_rise, LATCH_TO_VALID, in_txn);
               end
               total++;
               if (latch_len != 2 * HB) begin
                  bad++;
                  $display("FAIL latch_width got=%0d required=%0d", latch_len, 2 * HB);
               end
               total++;
               if (low_pulses != 8) begin
                  bad++;
                  $display("FAIL clk_pulses got=%0d required=8", low_pulses);
               end
               total++;
               if (sb_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_update got=%h required none", act);
               end else begin
                  e = sb_q.pop_front();
                  total++;
                  if (act !== e) begin
                     bad++;
                     $display("FAIL scoreboard got=%h required=%h", act, e);
                  end
               end
               in_txn = 0;
               upd_cnt++;
            end else begin
               total++;
               if (act !== prev_act) begin
                  bad++;
                  $display("FAIL hold got=%h required=%h", act, prev_act);
               end
            end
         end
         prev_latch = pad_latch;
         prev_clk   = pad_clk;
         prev_act   = act;
      end
   end

   task automatic wait_update(input string name);
      int start;
      bit got;
      start = upd_cnt;
      got = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #1;
         if (upd_cnt != start) begin
            got = 1;
            break;
         end
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s_timeout got=no update required=update within 400 cycles", name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         #1;
         total++;
         if (pad_latch !== 1'b0 || pad_clk !== 1'b1 || act !== '0 || sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got latch=%b clk=%b outs=%h sv=%b required 0/1/0/0",
                     pad_latch, pad_clk, act, sample_valid);
         end
      end
   endtask

   task automatic test_basic();
      raw_l = 8'hEF;
      raw_r = 8'hFF;
      sb_q.push_back(model(raw_l, raw_r));
      rst = 1'b0;
      wait_update("basic");
      total++;
      if (left_up !== 1'b1 || btn_l !== 8'h10 || pad_present_l !== 1'b1 || pad_present_r !== 1'b1) begin
         bad++;
         $display("FAIL basic_left_up got up=%b btn_l=%h pres=%b%b required 1/10/11",
                  left_up, btn_l, pad_present_l, pad_present_r);
      end
   endtask

   task automatic test_up_down();
      raw_l = 8'hCF;
      sb_q.push_back(model(raw_l, raw_r));
      wait_update("up_down");
      total++;
      if (left_up !== 1'b0 || left_down !== 1'b0 || btn_l !== 8'h30) begin
         bad++;
         $display("FAIL up_down got up=%b down=%b btn_l=%h required 0/0/30",
                  left_up, left_down, btn_l);
      end
   endtask

   task automatic test_disconnect();
      raw_l = 8'h00;
      raw_r = 8'hF7;
      sb_q.push_back(model(raw_l, raw_r));
      wait_update("disconnect");
      repeat (20) @(negedge clk);
      #1;
      total++;
      if (score_reset !== 1'b1 || btn_r !== 8'h08 || pad_present_l !== 1'b0 || btn_l !== 8'h00) begin
         bad++;
         $display("FAIL disconnect got sr=%b btn_r=%h pres_l=%b btn_l=%h required 1/08/0/00",
                  score_reset, btn_r, pad_present_l, btn_l);
      end
      sb_q.push_back(model(raw_l, raw_r));
      wait_update("disconnect_repeat");
   endtask

   task automatic test_reset_mid();
      bit   seen;
      int   falls;
      int   n;
      logic prev;
      raw_l = 8'hEF;
      raw_r = 8'hFF;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (pad_latch) begin
            seen = 1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL mid_latch_timeout got=no latch required=latch");
      end
      falls = 0;
      prev = pad_clk;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (prev && !pad_clk) falls++;
         prev = pad_clk;
         if (falls == 4) break;
      end
      total++;
      if (falls != 4) begin
         bad++;
         $display("FAIL mid_bit3 got falls=%0d required=4", falls);
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (pad_latch !== 1'b0 || pad_clk !== 1'b1 || act !== '0 || sample_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_state got latch=%b clk=%b outs=%h sv=%b required 0/1/0/0",
                  pad_latch, pad_clk, act, sample_valid);
      end
      rst = 1'b0;
      sb_q.push_back(model(raw_l, raw_r));
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         #1;
         if (pad_latch) break;
      end
      total++;
      if (n != PD) begin
         bad++;
         $display("FAIL mid_restart got edges=%0d required=%0d", n, PD);
      end
      wait_update("reset_mid");
   endtask

   task automatic test_back_to_back();
      raw_l = 8'hFF;
      raw_r = 8'hDF;
      sb_q.push_back(model(raw_l, raw_r));
      wait_update("b2b_first");
      total++;
      if (right_down !== 1'b1) begin
         bad++;
         $display("FAIL b2b_down_set got=%b required=1", right_down);
      end
      raw_r = 8'hFF;
      sb_q.push_back(model(raw_l, raw_r));
      wait_update("b2b_second");
      total++;
      if (right_down !== 1'b0) begin
         bad++;
         $display("FAIL b2b_down_clear got=%b required=0", right_down);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_up_down();
      test_disconnect();
      test_reset_mid();
      test_back_to_back();
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expect got=%0d required=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
